// File: rtl/snake_dpb_port_arbiter.sv
// Two-client weighted round-robin arbiter for one port of the snake-map DPB BSRAM.
// Registers the memory command and routes read data back to the issuing client.
module snake_dpb_port_arbiter #(
    parameter int ADDR_W  = 11,
    parameter int DATA_W  = 8,
    parameter int RD_LAT  = 2,
    parameter int WEIGHT0 = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              r0_req_i,
    input  logic              r0_wr_i,
    input  logic [ADDR_W-1:0] r0_addr_i,
    input  logic [DATA_W-1:0] r0_wdata_i,
    input  logic              r1_req_i,
    input  logic              r1_wr_i,
    input  logic [ADDR_W-1:0] r1_addr_i,
    input  logic [DATA_W-1:0] r1_wdata_i,
    output logic              r0_gnt_o,
    output logic              r1_gnt_o,
    output logic              r0_rvalid_o,
    output logic              r1_rvalid_o,
    output logic [DATA_W-1:0] r0_rdata_o,
    output logic [DATA_W-1:0] r1_rdata_o,
    output logic              m_ce_o,
    output logic              m_oce_o,
    output logic              m_wre_o,
    output logic [ADDR_W-1:0] m_addr_o,
    output logic [DATA_W-1:0] m_din_o,
    input  logic [DATA_W-1:0] m_dout_i,
    output logic              busy_o
);

    localparam int         TAG_D = RD_LAT + 1;
    localparam logic [3:0] W0    = 4'(WEIGHT0);

    logic              last_owner_q, last_owner_d;
    logic [3:0]        run_cnt_q, run_cnt_d;
    logic              gnt0, gnt1, accept;
    logic              sel_wr;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    logic              m_ce_q, m_wre_q, m_oce_q;
    logic [ADDR_W-1:0] m_addr_q;
    logic [DATA_W-1:0] m_din_q;

    logic [TAG_D-1:0]  tag_vld_q, tag_id_q;
    logic [DATA_W-1:0] r0_rdata_q, r1_rdata_q;
    logic              r0_rvalid, r1_rvalid;

    // Requester 1 only takes a contended slot once requester 0 has used up its weight.
    always_comb begin
        gnt1      = r1_req_i & (~r0_req_i | (~last_owner_q & (run_cnt_q >= W0)));
        gnt0      = r0_req_i & ~gnt1;
        accept    = gnt0 | gnt1;
        sel_wr    = gnt1 ? r1_wr_i    : r0_wr_i;
        sel_addr  = gnt1 ? r1_addr_i  : r0_addr_i;
        sel_wdata = gnt1 ? r1_wdata_i : r0_wdata_i;
    end

    always_comb begin
        last_owner_d = last_owner_q;
        run_cnt_d    = run_cnt_q;
        if (gnt1) begin
            last_owner_d = 1'b1;
            run_cnt_d    = 4'd0;
        end else if (gnt0) begin
            last_owner_d = 1'b0;
            if (last_owner_q)
                run_cnt_d = 4'd1;
            else if (run_cnt_q != 4'hF)
                run_cnt_d = run_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_owner_q <= 1'b1;
            run_cnt_q    <= 4'd0;
            m_ce_q       <= 1'b0;
            m_wre_q      <= 1'b0;
            m_oce_q      <= 1'b1;
            m_addr_q     <= '0;
            m_din_q      <= '0;
            tag_vld_q    <= '0;
            tag_id_q     <= '0;
            r0_rdata_q   <= '0;
            r1_rdata_q   <= '0;
        end else begin
            last_owner_q <= last_owner_d;
            run_cnt_q    <= run_cnt_d;
            m_ce_q       <= accept;
            m_wre_q      <= accept & sel_wr;
            m_oce_q      <= 1'b1;
            if (accept) begin
                m_addr_q <= sel_addr;
                m_din_q  <= sel_wdata;
            end
            tag_vld_q <= {tag_vld_q[TAG_D-2:0], accept & ~sel_wr};
            tag_id_q  <= {tag_id_q[TAG_D-2:0], gnt1};
            if (r0_rvalid) r0_rdata_q <= m_dout_i;
            if (r1_rvalid) r1_rdata_q <= m_dout_i;
        end
    end

    // Tag leaves the shift register in the same cycle the BSRAM presents dout.
    assign r0_rvalid = tag_vld_q[RD_LAT] & ~tag_id_q[RD_LAT];
    assign r1_rvalid = tag_vld_q[RD_LAT] &  tag_id_q[RD_LAT];

    assign r0_gnt_o    = gnt0;
    assign r1_gnt_o    = gnt1;
    assign r0_rvalid_o = r0_rvalid;
    assign r1_rvalid_o = r1_rvalid;
    assign r0_rdata_o  = r0_rvalid ? m_dout_i : r0_rdata_q;
    assign r1_rdata_o  = r1_rvalid ? m_dout_i : r1_rdata_q;
    assign m_ce_o      = m_ce_q;
    assign m_oce_o     = m_oce_q;
    assign m_wre_o     = m_wre_q;
    assign m_addr_o    = m_addr_q;
    assign m_din_o     = m_din_q;
    assign busy_o      = m_ce_q | (|tag_vld_q);

endmodule

// File: tb/tb_snake_dpb_port_arbiter.sv
// Scoreboard bench for snake_dpb_port_arbiter: expected commands and read returns are
// queued at grant time and checked by a monitor against the BSRAM pins and rvalid strobes.
module tb_snake_dpb_port_arbiter;
    localparam int RD_LAT = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        r0_req, r0_wr, r1_req, r1_wr;
    logic [10:0] r0_addr, r1_addr;
    logic [7:0]  r0_wdata, r1_wdata;
    logic        r0_gnt, r1_gnt, r0_rvalid, r1_rvalid;
    logic [7:0]  r0_rdata, r1_rdata;
    logic        m_ce, m_oce, m_wre, busy;
    logic [10:0] m_addr;
    logic [7:0]  m_din, m_dout;

    logic        b_req;
    logic        b_r0_gnt, b_r1_gnt, b_r0_rvalid, b_r1_rvalid;
    logic [7:0]  b_r0_rdata, b_r1_rdata;
    logic        b_m_ce, b_m_oce, b_m_wre, b_busy;
    logic [10:0] b_m_addr;
    logic [7:0]  b_m_din;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct { logic id; logic [7:0] data; int due; } rd_t;
    typedef struct { int due; logic wr; logic [10:0] addr; logic [7:0] din; } cmd_t;
    rd_t  rd_q[$];
    cmd_t cmd_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    snake_dpb_port_arbiter #(.ADDR_W(11), .DATA_W(8), .RD_LAT(RD_LAT), .WEIGHT0(2)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .r0_req_i(r0_req), .r0_wr_i(r0_wr), .r0_addr_i(r0_addr), .r0_wdata_i(r0_wdata),
        .r1_req_i(r1_req), .r1_wr_i(r1_wr), .r1_addr_i(r1_addr), .r1_wdata_i(r1_wdata),
        .r0_gnt_o(r0_gnt), .r1_gnt_o(r1_gnt),
        .r0_rvalid_o(r0_rvalid), .r1_rvalid_o(r1_rvalid),
        .r0_rdata_o(r0_rdata), .r1_rdata_o(r1_rdata),
        .m_ce_o(m_ce), .m_oce_o(m_oce), .m_wre_o(m_wre),
        .m_addr_o(m_addr), .m_din_o(m_din), .m_dout_i(m_dout), .busy_o(busy)
    );

    snake_dpb_port_arbiter #(.ADDR_W(11), .DATA_W(8), .RD_LAT(RD_LAT), .WEIGHT0(1)) dut_w1 (
        .clk_i(clk), .rst_ni(rst_n),
        .r0_req_i(b_req), .r0_wr_i(1'b0), .r0_addr_i(11'h000), .r0_wdata_i(8'h00),
        .r1_req_i(b_req), .r1_wr_i(1'b0), .r1_addr_i(11'h001), .r1_wdata_i(8'h00),
        .r0_gnt_o(b_r0_gnt), .r1_gnt_o(b_r1_gnt),
        .r0_rvalid_o(b_r0_rvalid), .r1_rvalid_o(b_r1_rvalid),
        .r0_rdata_o(b_r0_rdata), .r1_rdata_o(b_r1_rdata),
        .m_ce_o(b_m_ce), .m_oce_o(b_m_oce), .m_wre_o(b_m_wre),
        .m_addr_o(b_m_addr), .m_din_o(b_m_din), .m_dout_i(8'h00), .busy_o(b_busy)
    );

    // BSRAM port model with output register (read latency 2), preloaded while in reset.
    logic [7:0] mem [2048];
    logic [7:0] mem_lat;
    always @(posedge clk) begin
        if (!rst_n) begin
            mem[11'h005] <= 8'h3C;
            mem[11'h100] <= 8'h11;
            mem[11'h101] <= 8'h22;
        end else if (m_ce) begin
            if (m_wre) mem[m_addr] <= m_din;
            else       mem_lat     <= mem[m_addr];
        end
        if (m_oce) m_dout <= mem_lat;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic note_grant(input logic id, input logic wr, input logic [10:0] addr,
                              input logic [7:0] wd, input logic [7:0] exp);
        cmd_t c;
        rd_t  r;
        c.due = cyc + 1; c.wr = wr; c.addr = addr; c.din = wd;
        cmd_q.push_back(c);
        if (!wr) begin
            r.id = id; r.data = exp; r.due = cyc + 1 + RD_LAT;
            rd_q.push_back(r);
        end
    endtask

    task automatic mon_loop();
        rd_t  r;
        cmd_t c;
        forever begin
            @(negedge clk);
            if (r0_rvalid || r1_rvalid) begin
                if (r0_rvalid && r1_rvalid) begin
                    chk("rvalid_both", {r0_rvalid, r1_rvalid}, 2'b00);
                end else if (rd_q.size() == 0) begin
                    chk("rvalid_unexpected", {r0_rvalid, r1_rvalid}, 2'b00);
                end else begin
                    r = rd_q.pop_front();
                    chk("rd_id", r1_rvalid, r.id);
                    chk("rd_data", r1_rvalid ? r1_rdata : r0_rdata, r.data);
                    chk("rd_cycle", cyc, r.due);
                end
            end
            if (m_ce) begin
                if (cmd_q.size() == 0) begin
                    chk("cmd_unexpected_addr", m_addr, 11'h7FF ^ m_addr);
                end else begin
                    c = cmd_q.pop_front();
                    chk("cmd_cycle", cyc, c.due);
                    chk("cmd_wre", m_wre, c.wr);
                    chk("cmd_addr", m_addr, c.addr);
                    chk("cmd_din", m_din, c.din);
                end
            end
        end
    endtask

    task automatic issue(input logic id, input logic wr, input logic [10:0] addr,
                         input logic [7:0] wd, input logic [7:0] exp, output int gc);
        logic got = 1'b0;
        gc = -1;
        if (id) begin r1_req = 1'b1; r1_wr = wr; r1_addr = addr; r1_wdata = wd; end
        else    begin r0_req = 1'b1; r0_wr = wr; r0_addr = addr; r0_wdata = wd; end
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (id ? r1_gnt : r0_gnt) begin
                got = 1'b1;
                gc  = cyc;
                note_grant(id, wr, addr, wd, exp);
            end
            @(posedge clk); #1;
        end
        if (id) r1_req = 1'b0; else r0_req = 1'b0;
        if (!got) chk("grant_timeout", 32'd0, 32'd1);
    endtask

    int exp_a [6] = '{0, 0, 1, 0, 0, 1};
    int exp_b [6] = '{0, 1, 0, 1, 0, 1};
    int wt, g;

    initial begin
        rst_n = 1'b0;
        r0_req = 0; r0_wr = 0; r0_addr = '0; r0_wdata = '0;
        r1_req = 0; r1_wr = 0; r1_addr = '0; r1_wdata = '0;
        b_req = 0;
        fork mon_loop(); join_none

        repeat (2) @(negedge clk);
        chk("rst_m_ce", m_ce, 0);
        chk("rst_m_wre", m_wre, 0);
        chk("rst_m_oce", m_oce, 1);
        chk("rst_m_addr", m_addr, 0);
        chk("rst_m_din", m_din, 0);
        chk("rst_rvalid", {r0_rvalid, r1_rvalid}, 0);
        chk("rst_rdata", {r0_rdata, r1_rdata}, 0);
        chk("rst_busy", busy, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Continuous contention from reset on both weight settings.
        r0_req = 1; r0_wr = 0; r0_addr = 11'h100; r0_wdata = 8'h00;
        r1_req = 1; r1_wr = 0; r1_addr = 11'h101; r1_wdata = 8'h00;
        b_req  = 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("cont_one_hot", r0_gnt & r1_gnt, 0);
            chk("cont_w2_r1", r1_gnt, exp_a[i]);
            chk("cont_w2_any", r0_gnt | r1_gnt, 1);
            chk("cont_w1_r1", b_r1_gnt, exp_b[i]);
            chk("cont_w1_r0", b_r0_gnt, 1 - exp_b[i]);
            if (r1_gnt)      note_grant(1, 0, 11'h101, 8'h00, 8'h22);
            else if (r0_gnt) note_grant(0, 0, 11'h100, 8'h00, 8'h11);
            @(posedge clk); #1;
        end
        r0_req = 0; r1_req = 0; b_req = 0;
        repeat (6) @(posedge clk); #1;

        // Single read, no contention.
        issue(0, 0, 11'h005, 8'h00, 8'h3C, g);
        repeat (6) @(posedge clk); #1;

        // Write then read of the same address in consecutive cycles.
        issue(1, 1, 11'h0A7, 8'h5A, 8'h00, wt);
        issue(1, 0, 11'h0A7, 8'h00, 8'h5A, g);
        chk("wr_rd_b2b", g, wt + 1);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!busy) break;
        end
        chk("busy_clear_cycle", cyc, wt + 5);
        @(posedge clk); #1;

        // r0 burst; r1 raises a read for one cycle and withdraws before it can win.
        r0_req = 1; r0_wr = 0; r0_addr = 11'h100; r0_wdata = 8'h00;
        r1_wr = 0; r1_addr = 11'h7FF;
        for (int i = 0; i < 4; i++) begin
            r1_req = (i == 1);
            @(negedge clk);
            chk("wd_r0_gnt", r0_gnt, 1);
            chk("wd_r1_gnt", r1_gnt, 0);
            if (r0_gnt) note_grant(0, 0, 11'h100, 8'h00, 8'h11);
            @(posedge clk); #1;
        end
        r0_req = 0; r1_req = 0;
        repeat (6) @(posedge clk); #1;

        // Reset while two reads are in flight.
        r0_req = 1; r0_wr = 0; r0_addr = 11'h005;
        @(negedge clk);
        chk("rm_r0_gnt", r0_gnt, 1);
        if (r0_gnt) begin : push_first
            cmd_t c;
            c.due = cyc + 1; c.wr = 1'b0; c.addr = 11'h005; c.din = 8'h00;
            cmd_q.push_back(c);
        end
        @(posedge clk); #1;
        r0_req = 0;
        r1_req = 1; r1_wr = 0; r1_addr = 11'h101; r1_wdata = 8'h00;
        @(negedge clk);
        chk("rm_r1_gnt", r1_gnt, 1);
        @(posedge clk); #1;
        r1_req = 0;
        rst_n  = 1'b0;
        @(negedge clk);
        chk("rm_m_ce", m_ce, 0);
        chk("rm_busy", busy, 0);
        chk("rm_rvalid", {r0_rvalid, r1_rvalid}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        r0_req = 1; r0_wr = 0; r0_addr = 11'h100; r0_wdata = 8'h00;
        r1_req = 1; r1_wr = 0; r1_addr = 11'h101; r1_wdata = 8'h00;
        @(negedge clk);
        chk("post_rst_r0_gnt", r0_gnt, 1);
        chk("post_rst_r1_gnt", r1_gnt, 0);
        if (r0_gnt) note_grant(0, 0, 11'h100, 8'h00, 8'h11);
        @(posedge clk); #1;
        r0_req = 0; r1_req = 0;

        repeat (8) @(posedge clk);
        @(negedge clk);
        chk("rd_queue_drained", rd_q.size(), 0);
        chk("cmd_queue_drained", cmd_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/snake_dpb_port_arbiter.md
# snake_dpb_port_arbiter

Two-requester arbiter sharing one port of the snake-map dual-port BSRAM (Gowin DPB, 11-bit address, 8-bit data). It sits between the memory port and two clients, typically the map reader that feeds the HDMI renderer and a collision/food checker. It grants one access per cycle using weighted round-robin, drives the BSRAM port pins, and returns read data to the issuing client with a valid strobe aligned to the memory read latency.

## Interface
- ADDR_W, 11, BSRAM address width
- DATA_W, 8, BSRAM data width
- RD_LAT, 2, edges from the memory sampling a read command to dout valid (1 = bypass, 2 = output register)
- WEIGHT0, 2, max consecutive grants to requester 0 while requester 1 waits (1..15)

- clk  in  1  system clock, shared with the BSRAM port
- rst  in  1  asynchronous, active-low reset
- r0_req / r1_req  in  1  access request, held until granted
- r0_wr / r1_wr  in  1  1 = write, 0 = read (qualified by req)
- r0_addr / r1_addr  in  ADDR_W  access address
- r0_wdata / r1_wdata  in  DATA_W  write data
- r0_gnt / r1_gnt  out  1  combinational; request accepted this cycle
- r0_rvalid / r1_rvalid  out  1  one-cycle pulse, read data valid
- r0_rdata / r1_rdata  out  DATA_W  read data, valid only with rvalid
- m_ce  out  1  BSRAM clock enable (cea/ceb)
- m_oce  out  1  BSRAM output-register enable
- m_wre  out  1  BSRAM write enable
- m_addr  out  ADDR_W  BSRAM address
- m_din  out  DATA_W  BSRAM write data
- m_dout  in  DATA_W  BSRAM read data
- busy  out  1  command or read still in flight

## Operation
- Accept: request X is accepted in cycle T when rX_req=1 and rX_gnt=1. At most one gnt high per cycle. gnt depends only on req and registered state.
- Withdrawal: a client may drop req before gnt; the request then never happened. After gnt, the fields are captured, so the client may change them on T+1.
- Arbitration state: last_owner (0/1) and run_cnt (4 bits, consecutive grants to requester 0).
  - Only one requester active: it wins. run_cnt is still updated.
  - Both active: requester 1 wins if last_owner=0 and run_cnt >= WEIGHT0. Otherwise requester 0 wins if last_owner=1. Otherwise (last_owner=0, run_cnt < WEIGHT0) requester 0 wins.
  - Grant to 0: run_cnt <= (last_owner==0) ? sat(run_cnt+1) : 1; last_owner <= 0.
  - Grant to 1: run_cnt <= 0; last_owner <= 1.
  - No grant: state holds.
- Command stage (registered): on the accept edge, m_ce<=1, m_wre<=wr, m_addr<=addr, m_din<=wdata. With no accept, m_ce<=0 and m_wre<=0. m_addr and m_din hold their last values.
- m_oce is a register, 1 after reset.
- Read return: a tag shift register {valid, id} of depth RD_LAT+1 is loaded on the accept edge, with valid = ~wr. When the tag exits, rX_rvalid=1 for the matching id and rX_rdata=m_dout (combinational pass-through). The non-matching rdata holds its last value.
- Writes produce no rvalid.
- busy = m_ce | any tag valid.

## Timing
- Reset values: m_ce=0, m_wre=0, m_oce=1, m_addr=0, m_din=0, r0_rvalid=r1_rvalid=0, rdata=0, busy=0, last_owner=1, run_cnt=0, all tags invalid. Requester 0 wins the first contention.
- Read accepted in T: m_* valid during T+1, memory samples at the end of T+1, rvalid high during T+1+RD_LAT. Default RD_LAT=2 gives T+3.
- Write accepted in T: committed at the end of T+1.
- Back-to-back: one access per cycle sustained; the pipeline holds up to RD_LAT+1 reads.
- Read-after-write to the same address, accepted in consecutive cycles: returns the new data (the BSRAM sees write then read in order).
- Reset asserted mid-operation: all tags cleared immediately. No rvalid appears after reset release for pre-reset reads. m_ce drops asynchronously.

## Test plan
- Single read: r0 reads addr 0x005 holding 0x3C, no contention -> r0_gnt in T, m_ce=1 / m_addr=0x005 in T+1, r0_rvalid=1 with r0_rdata=0x3C in T+3, r1_rvalid stays 0.
- Write then read: r1 writes 0x0A7=0x5A in T, then reads 0x0A7 in T+1 -> r1_rvalid in T+4 with 0x5A; busy clears in T+5.
- Contention, WEIGHT0=2: both request continuously from reset -> grant order 0,0,1,0,0,1,…
- Contention, WEIGHT0=1: same stimulus -> grant order 0,1,0,1.
- Withdrawal: r1 raises req for a read during an r0 burst, then drops it before gnt -> no r1 access on m_*, no r1_rvalid.
- Reset mid-read: reads accepted in T and T+1, rst low in T+2 for one cycle -> no rvalid ever, m_ce=0 and busy=0 during reset, first post-reset contention goes to r0.
